// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue between fetch port and IF/ID
// Optional zero-latency empty-queue bypass enabled by FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [XLEN-1:0]          in_pc_i,
  input  logic [XLEN-1:0]          in_instr_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [XLEN-1:0]          out_instr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            empty;
  logic            bypass_hit;
  logic            head_valid;
  logic            push_en;
  logic            pop_en;

  assign empty      = (count_q == '0);
  assign in_ready_o = rst_n && (count_q < CW'(DEPTH));
  assign count_o    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue forwards the fetch entry straight through; gated by reset so
  // the outputs stay quiet while rst_n is low.
  assign bypass_hit = rst_n && empty && in_valid_i && !flush_i;
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_valid  = !empty;
  assign out_valid_o = head_valid || bypass_hit;

  // A bypassed entry consumed in the same cycle never lands in storage.
  assign push_en = in_valid_i && in_ready_o && !flush_i && !(bypass_hit && out_ready_i);
  assign pop_en  = head_valid && out_ready_i && !flush_i;

  always_comb begin
    out_pc_o    = '0;
    out_instr_o = NOP;
    if (bypass_hit) begin
      out_pc_o    = in_pc_i;
      out_instr_o = in_instr_i;
    end else if (head_valid) begin
      out_pc_o    = pc_mem[rd_ptr_q];
      out_instr_o = instr_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      pc_mem[wr_ptr_q]    <= in_pc_i;
      instr_mem[wr_ptr_q] <= in_instr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue (honours FETCH_QUEUE_BYPASS_EN)
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc = '0;
  logic [XLEN-1:0]  in_instr = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_instr;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_pc_i(in_pc), .in_instr_i(in_instr),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_instr_o(out_instr),
    .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ent_t;

  ent_t            exp_q[$];
  int              mdl_cnt = 0;
  bit              mon_en = 1'b0;
  int              errors = 0;
  int              checks = 0;
  logic [XLEN-1:0] pc_ctr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state is the occupancy after the previous edge; an accepted entry is
  // queued as soon as it is offered so a bypass can be scored in the same cycle.
  task automatic cyc(input bit v, input bit rdy, input bit fl);
    @(posedge clk);
    #1;
    mdl_cnt   = exp_q.size();
    in_valid  = v;
    in_pc     = pc_ctr;
    in_instr  = $urandom;
    out_ready = rdy;
    flush     = fl;
    if (fl) exp_q.delete();
    else if (v && mdl_cnt < DEPTH) begin
      exp_q.push_back('{pc: in_pc, instr: in_instr});
      pc_ctr = pc_ctr + 32'd4;
    end
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit   exp_v;
      ent_t e;
      exp_v = (mdl_cnt != 0) || (BYP && in_valid && !flush && mdl_cnt == 0);
      chk("count", 64'(count), 64'(mdl_cnt));
      chk("in_ready", 64'(in_ready), 64'(mdl_cnt < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      if (!exp_v) begin
        chk("idle_instr", 64'(out_instr), 64'h13);
        chk("idle_pc", 64'(out_pc), 64'h0);
      end else if (!flush) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL scoreboard_empty: got output pc %0h expected none", out_pc);
        end else begin
          e = exp_q[0];
          chk("head_pc", 64'(out_pc), 64'(e.pc));
          chk("head_instr", 64'(out_instr), 64'(e.instr));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset held for three cycles, then released
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_instr", 64'(out_instr), 64'h13);
      chk("rst_pc", 64'(out_pc), 64'h0);
      chk("rst_count", 64'(count), 64'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready), 64'h1);

    repeat (5) cyc(1, 0, 0);                      // fill, fifth held pending
    repeat (5) cyc(0, 1, 0);                      // drain in order
    repeat (10) begin cyc(1, 0, 0); cyc(0, 1, 0); end
    repeat (2) cyc(1, 0, 0);                      // push+pop at count 2
    cyc(1, 1, 0);
    repeat (3) cyc(0, 1, 0);
    repeat (3) cyc(1, 0, 0);                      // flush with concurrent push/pop
    cyc(1, 1, 1);
    cyc(0, 1, 0);
    pc_ctr = 32'h100;                             // push into empty queue, consumer ready
    cyc(1, 1, 0);
    cyc(0, 1, 0);

    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, ($urandom % 2) != 0, ($urandom % 25) == 0);

    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'h0);
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    chk("async_rst_ready", 64'(in_ready), 64'h0);
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("async_release_ready", 64'(in_ready), 64'h1);

    for (int i = 0; i < 300; i++)
      cyc(($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0);

    repeat (DEPTH + 2) cyc(0, 1, 0);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("drained", 64'(exp_q.size()), 64'h0);
    chk("final_count", 64'(count), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
